riscv_dmi_arbiter: RTL
======================

// Module: riscv_dmi_arbiter
// PURPOSE
//  Shares the single DMI request/response port of the Debug Module between N requesters
//  (e.g. JTAG DTM and a system-bus debug access port). Round-robin arbitration.
//  Exactly one transaction is outstanding at a time. The response is routed back to the
//  requester that issued the request. A response timeout returns a failed op so a requester
//  is never hung by a silent DM.
// PARAMETERS
//  N_REQ          2     number of requesters (>=2)
//  ADDR_W         7     DMI address width
//  DATA_W         32    DMI data width
//  OP_W           2     DMI op width
//  TIMEOUT_CYCLES 1024  clk_i cycles in WAIT before a failed response; 0 = timeout disabled
// PORTS
//  clk_i          in   1             DM-side clock
//  trst_i         in   1             reset, asynchronous, active-high
//  s_req_valid_i  in   N_REQ         per-requester request valid
//  s_req_ready_o  out  N_REQ         per-requester request accept (one-hot or 0)
//  s_req_addr_i   in   N_REQ*ADDR_W  slice i = [i*ADDR_W +: ADDR_W]
//  s_req_data_i   in   N_REQ*DATA_W  slice i = [i*DATA_W +: DATA_W]
//  s_req_op_i     in   N_REQ*OP_W    slice i = [i*OP_W +: OP_W]
//  s_resp_valid_o out  N_REQ         response valid, one-hot to the owner
//  s_resp_ready_i in   N_REQ         per-requester response accept
//  s_resp_data_o  out  DATA_W        response data (shared bus)
//  s_resp_op_o    out  OP_W          response op (shared bus)
//  m_req_valid_o  out  1             request to DM
//  m_req_ready_i  in   1
//  m_req_addr_o   out  ADDR_W        request address to DM
//  m_req_data_o   out  DATA_W        request data to DM
//  m_req_op_o     out  OP_W          request op to DM
//  m_resp_valid_i in   1             response from DM
//  m_resp_ready_o out  1
//  m_resp_data_i  in   DATA_W        response data from DM
//  m_resp_op_i    in   OP_W          response op from DM
//  grant_idx_o    out  $clog2(N_REQ) current/last owner
//  busy_o         out  1             state != IDLE
//  timeout_o      out  1             sticky; set on any timeout, cleared only by trst_i
// BEHAVIOUR
//  Reset (async, trst_i=1):
//   - all valid/ready outputs 0, state IDLE, grant_idx_o 0, busy_o 0, timeout_o 0.
//   - last-grant pointer = N_REQ-1, so requester 0 wins first.
//   - latched request/response registers 0.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, plus DRAIN.
//  IDLE:
//   - Search s_req_valid_i starting at (last+1) mod N_REQ, wrapping.
//   - On winner g: s_req_ready_o[g]=1 combinationally in the same cycle.
//   - Latch g and its addr/data/op; next state ISSUE. No other requester sees ready.
//  ISSUE:
//   - m_req_valid_o=1, driven from the latched fields, held stable until m_req_ready_i.
//   - On m_req_ready_i: next state WAIT, timeout counter cleared.
//  WAIT:
//   - m_resp_ready_o=1. On m_resp_valid_i: latch data/op; next state RESP.
//   - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES (if nonzero):
//     latch data=0, op=2 (failed), set timeout_o and an internal drain flag; next state RESP.
//   - If the response and the terminal count land in the same cycle, the response wins
//     (no timeout).
//  RESP:
//   - s_resp_valid_o[g]=1 with the latched data/op, held until s_resp_ready_i[g].
//   - On handshake: last=g; next state IDLE, or DRAIN if the drain flag is set.
//   - m_resp_ready_o=0 in RESP.
//  DRAIN:
//   - m_resp_ready_o=1. The first m_resp_valid_i is discarded; clear the drain flag and go
//     to IDLE. No grants while in DRAIN.
//  Latency, no contention, DM ready/response immediate:
//   - s_req handshake cycle 0; m_req_valid_o cycle 1; s_resp_valid_o cycle 3.
//  Boundaries:
//   - Simultaneous requests pick the next index after last. The non-selected requester
//     keeps valid and must not be dropped.
//   - s_req_valid_i deasserting while not granted has no effect.
//   - m_resp_valid_i outside WAIT/DRAIN is ignored.
//   - trst_i mid-transaction aborts to IDLE immediately. No response is delivered.
// TESTING
//  - Single req0 addr=0x10 data=0xDEADBEEF op=2, DM ready+resp same cycle, resp data=0x12345678 op=0
//    -> req0 gets resp 0x12345678/op0 at cycle 3; s_resp_valid_o[1] never set.
//  - req0 and req1 valid continuously for 4 transactions -> grants 0,1,0,1.
//    The DM sees each requester's addr unchanged.
//  - TIMEOUT_CYCLES=8, DM accepts but never responds
//    -> owner gets op=2 data=0 after 8 WAIT cycles; timeout_o=1.
//    State DRAIN; a later req1 is not granted until the DM response arrives and is discarded.
//  - DM holds m_req_ready_i=0 for 20 cycles -> m_req_valid_o and fields stable; no timeout.
//  - Response arrives in the exact terminal-count cycle -> real data/op delivered; timeout_o=0.
//  - trst_i asserted during WAIT -> all outputs 0 asynchronously.
//    After release, req0 is granted first.

Source files
------------

// File: rtl/riscv_dmi_arbiter_if.sv
// rtl/riscv_dmi_arbiter_if.sv - DMI requester/DM bundle shared by the arbiter and its environment
//
// Purpose: groups the requester-side (s_*) and DM-side (m_*) handshake buses of
// riscv_dmi_arbiter. Signal suffixes are from the arbiter's point of view.
//   slave  modport: the arbiter itself (s_req_*_i / m_resp_*_i in, s_resp_*_o / m_req_*_o out)
//   master modport: the surrounding requesters and Debug Module
// Per-requester request fields are packed, slice i = [i*W +: W].
interface riscv_dmi_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int OP_W   = 2
);
   logic [N_REQ-1:0]        s_req_valid_i;
   logic [N_REQ-1:0]        s_req_ready_o;
   logic [N_REQ*ADDR_W-1:0] s_req_addr_i;
   logic [N_REQ*DATA_W-1:0] s_req_data_i;
   logic [N_REQ*OP_W-1:0]   s_req_op_i;
   logic [N_REQ-1:0]        s_resp_valid_o;
   logic [N_REQ-1:0]        s_resp_ready_i;
   logic [DATA_W-1:0]       s_resp_data_o;
   logic [OP_W-1:0]         s_resp_op_o;
   logic                    m_req_valid_o;
   logic                    m_req_ready_i;
   logic [ADDR_W-1:0]       m_req_addr_o;
   logic [DATA_W-1:0]       m_req_data_o;
   logic [OP_W-1:0]         m_req_op_o;
   logic                    m_resp_valid_i;
   logic                    m_resp_ready_o;
   logic [DATA_W-1:0]       m_resp_data_i;
   logic [OP_W-1:0]         m_resp_op_i;

   modport slave (
      input  s_req_valid_i, s_req_addr_i, s_req_data_i, s_req_op_i, s_resp_ready_i,
      input  m_req_ready_i, m_resp_valid_i, m_resp_data_i, m_resp_op_i,
      output s_req_ready_o, s_resp_valid_o, s_resp_data_o, s_resp_op_o,
      output m_req_valid_o, m_req_addr_o, m_req_data_o, m_req_op_o, m_resp_ready_o
   );

   modport master (
      output s_req_valid_i, s_req_addr_i, s_req_data_i, s_req_op_i, s_resp_ready_i,
      output m_req_ready_i, m_resp_valid_i, m_resp_data_i, m_resp_op_i,
      input  s_req_ready_o, s_resp_valid_o, s_resp_data_o, s_resp_op_o,
      input  m_req_valid_o, m_req_addr_o, m_req_data_o, m_req_op_o, m_resp_ready_o
   );
endinterface

// File: rtl/riscv_dmi_arbiter.sv
// rtl/riscv_dmi_arbiter.sv - round-robin arbiter sharing one DMI port between N requesters
//
// Purpose: one transaction outstanding at a time; response routed back to the owner;
// a silent DM produces a failed (op=2) response after TIMEOUT_CYCLES in WAIT, and the
// late DM response is then drained and discarded.
// Ports:
//   clk_i       DM-side clock
//   trst_i      asynchronous active-high reset
//   bus         riscv_dmi_arbiter_if.slave: requester and DM handshake buses
//   grant_idx_o current/last owner
//   busy_o      arbiter not idle
//   timeout_o   sticky timeout flag, cleared only by trst_i
module riscv_dmi_arbiter #(
   parameter int N_REQ          = 2,
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 32,
   parameter int OP_W           = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     trst_i,
   riscv_dmi_arbiter_if.slave       bus,
   output logic [$clog2(N_REQ)-1:0] grant_idx_o,
   output logic                     busy_o,
   output logic                     timeout_o
);
   localparam int GNT_W = $clog2(N_REQ);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   // Counter value seen in the last WAIT cycle before the timeout fires.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [GNT_W-1:0]    gnt_q, last_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic [DATA_W-1:0]   req_data_q, rsp_data_q;
   logic [OP_W-1:0]     req_op_q, rsp_op_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                drain_q, timeout_q;

   logic                win_found;
   logic [GNT_W-1:0]    win_idx, cand;
   logic [N_REQ-1:0]    req_ready, resp_valid;
   logic                m_valid, m_rready;
   logic                take_req, issue_done, resp_take, timeout_hit, resp_done, drain_done;

   // Round-robin search starting just after the last owner, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = GNT_W'((int'(last_q) + k) % N_REQ);
         if (!win_found && bus.s_req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = '0;
      resp_valid  = '0;
      m_valid     = 1'b0;
      m_rready    = 1'b0;
      take_req    = 1'b0;
      issue_done  = 1'b0;
      resp_take   = 1'b0;
      timeout_hit = 1'b0;
      resp_done   = 1'b0;
      drain_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by reset so no ready escapes while trst_i is held.
            if (win_found && !trst_i) begin
               req_ready[win_idx] = 1'b1;
               take_req           = 1'b1;
               state_d            = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            m_valid = 1'b1;
            if (bus.m_req_ready_i) begin
               issue_done = 1'b1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            m_rready = 1'b1;
            // A response landing on the terminal count wins over the timeout.
            if (bus.m_resp_valid_i) begin
               resp_take = 1'b1;
               state_d   = ST_RESP;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid[gnt_q] = 1'b1;
            if (bus.s_resp_ready_i[gnt_q]) begin
               resp_done = 1'b1;
               state_d   = drain_q ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // The DM still owes a response to the timed-out request; swallow it.
            m_rready = 1'b1;
            if (bus.m_resp_valid_i) begin
               drain_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge trst_i) begin
      if (trst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge trst_i) begin
      if (trst_i) begin
         gnt_q      <= '0;
         last_q     <= GNT_W'(N_REQ - 1);
         req_addr_q <= '0;
         req_data_q <= '0;
         req_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_op_q   <= '0;
         cnt_q      <= '0;
         drain_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         if (take_req) begin
            gnt_q      <= win_idx;
            req_addr_q <= bus.s_req_addr_i[win_idx*ADDR_W +: ADDR_W];
            req_data_q <= bus.s_req_data_i[win_idx*DATA_W +: DATA_W];
            req_op_q   <= bus.s_req_op_i[win_idx*OP_W +: OP_W];
         end
         if (issue_done) begin
            cnt_q <= '0;
         end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (resp_take) begin
            rsp_data_q <= bus.m_resp_data_i;
            rsp_op_q   <= bus.m_resp_op_i;
         end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_op_q   <= OP_W'(2);
            drain_q    <= 1'b1;
            timeout_q  <= 1'b1;
         end
         if (resp_done) begin
            last_q <= gnt_q;
         end
         if (drain_done) begin
            drain_q <= 1'b0;
         end
      end
   end

   assign bus.s_req_ready_o  = req_ready;
   assign bus.s_resp_valid_o = resp_valid;
   assign bus.s_resp_data_o  = rsp_data_q;
   assign bus.s_resp_op_o    = rsp_op_q;
   assign bus.m_req_valid_o  = m_valid;
   assign bus.m_req_addr_o   = req_addr_q;
   assign bus.m_req_data_o   = req_data_q;
   assign bus.m_req_op_o     = req_op_q;
   assign bus.m_resp_ready_o = m_rready;
   assign grant_idx_o        = gnt_q;
   assign busy_o             = (state_q != ST_IDLE);
   assign timeout_o          = timeout_q;
endmodule
